// File: rtl/ref_level_seq.sv
// Sequencer for the slicer reference-level accumulator: drives clear/hold so each
// latched ref_level is the mean |dec_var| over exactly 2^ACC_LOG2 symbols.
module ref_level_seq #(
    parameter int unsigned ACC_LOG2    = 22,
    parameter int unsigned SETTLE_SYMS = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    output logic             acc_clear,
    output logic             acc_hold,
    output logic             ref_valid,
    output logic             busy,
    output logic [CNT_W-1:0] window_count
);

    // sym_cnt is shared by SETTLE and ACCUM; one spare bit keeps the terminal compare overflow-free
    localparam int unsigned SYM_W = ACC_LOG2 + 1;

    localparam logic [SYM_W-1:0] WIN_LAST    = {1'b0, {ACC_LOG2{1'b1}}};
    localparam logic [SYM_W-1:0] SETTLE_LAST = SYM_W'(SETTLE_SYMS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ACCUM  = 3'd2,
        S_LATCH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SYM_W-1:0]   sym_cnt_q;
    logic [SYM_W-1:0]   sym_cnt_d;
    logic               ref_valid_d;
    logic [CNT_W-1:0]   window_count_d;
    logic               acc_clear_d;
    logic               acc_hold_d;
    logic               busy_d;

    // Next-state, counters and Moore decode of the next state
    always_comb begin
        state_d        = state_q;
        sym_cnt_d      = sym_cnt_q;
        ref_valid_d    = ref_valid;
        window_count_d = window_count;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_SETTLE;
                    sym_cnt_d = '0;
                end
            end
            S_SETTLE: begin
                if (clk_en) begin
                    if (sym_cnt_q == SETTLE_LAST) begin
                        state_d   = S_ACCUM;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + SYM_W'(1);
                    end
                end
            end
            S_ACCUM: begin
                if (clk_en) begin
                    if (sym_cnt_q == WIN_LAST) begin
                        state_d   = S_LATCH;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + SYM_W'(1);
                    end
                end
            end
            S_LATCH: begin
                // hold was high this cycle, so the latch completes even under abort
                if (clk_en) begin
                    ref_valid_d    = 1'b1;
                    window_count_d = window_count + CNT_W'(1);
                    sym_cnt_d      = '0;
                    state_d        = continuous ? S_ACCUM : S_DONE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                sym_cnt_d = '0;
            end
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            sym_cnt_d = '0;
        end

        acc_clear_d = (state_d != S_ACCUM);
        acc_hold_d  = (state_d == S_LATCH);
        busy_d      = (state_d == S_SETTLE) || (state_d == S_ACCUM) || (state_d == S_LATCH);
    end

    // State, counters and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sym_cnt_q    <= '0;
            ref_valid    <= 1'b0;
            window_count <= '0;
            acc_clear    <= 1'b1;
            acc_hold     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            ref_valid    <= ref_valid_d;
            window_count <= window_count_d;
            acc_clear    <= acc_clear_d;
            acc_hold     <= acc_hold_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_ref_level_seq.sv
// Directed bench for ref_level_seq with a behavioural accumulator driven by its controls.
module tb_ref_level_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       abort = 1'b0;
    logic       acc_clear;
    logic       acc_hold;
    logic       ref_valid;
    logic       busy;
    logic [3:0] window_count;

    int errors = 0;
    int checks = 0;

    int dec_var = 0;
    int acc_m = 0;
    int ref_m = 0;

    ref_level_seq #(.ACC_LOG2(3), .SETTLE_SYMS(2), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .acc_clear    (acc_clear),
        .acc_hold     (acc_hold),
        .ref_valid    (ref_valid),
        .busy         (busy),
        .window_count (window_count)
    );

    always #5 clk = ~clk;

    // Reference accumulator: latch on hold, zero on clear, else add |dec_var|
    always @(posedge clk) begin
        if (clk_en) begin
            if (acc_hold) ref_m <= acc_m >>> 3;
            acc_m <= acc_clear ? 0 : acc_m + ((dec_var < 0) ? -dec_var : dec_var);
        end
    end

    typedef struct {
        logic       start;
        logic       cont;
        logic       abort;
        logic       en;
        logic       clr;
        logic       hld;
        logic       vld;
        logic       bsy;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t v(input logic s, input logic c, input logic a, input logic e,
                               input logic cl, input logic h, input logic vl, input logic b,
                               input logic [3:0] n);
        vec_t r;
        r.start = s; r.cont = c; r.abort = a; r.en = e;
        r.clr = cl; r.hld = h; r.vld = vl; r.bsy = b; r.cnt = n;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: inputs applied before the edge, outputs settled #1 after it
    task automatic tick(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        reset  = 1'b0;
    endtask

    // One symbol strobe at the default every-second-clock rate
    task automatic sym();
        tick(1'b0);
        tick(1'b1);
    endtask

    task automatic chk_ctl(input string nm, input logic cl, input logic h, input logic vl,
                           input logic b, input logic [3:0] n);
        chk(nm, {24'd0, acc_clear, acc_hold, ref_valid, busy, window_count},
                {24'd0, cl, h, vl, b, n});
    endtask

    // Run strobes until window_count moves; returns strobes used (bounded)
    task automatic run_window(output int n);
        logic [3:0] prev;
        prev = window_count;
        n = 0;
        while (window_count == prev && n < 20) begin
            sym();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [3:0] exp_cnt;

        // Test 1: reset then idle
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(i[0]);
            chk_ctl("idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        end

        // Test 2: one-shot window, clock by clock
        tbl[0]  = v(1,0,0,0, 1,0,0,1,0);
        tbl[1]  = v(0,0,0,1, 1,0,0,1,0);
        tbl[2]  = v(0,0,0,0, 1,0,0,1,0);
        tbl[3]  = v(0,0,0,1, 0,0,0,1,0);
        tbl[4]  = v(0,0,0,1, 0,0,0,1,0);
        tbl[5]  = v(1,0,0,1, 0,0,0,1,0);
        tbl[6]  = v(0,0,0,1, 0,0,0,1,0);
        tbl[7]  = v(0,0,0,1, 0,0,0,1,0);
        tbl[8]  = v(0,0,0,1, 0,0,0,1,0);
        tbl[9]  = v(0,0,0,1, 0,0,0,1,0);
        tbl[10] = v(0,0,0,1, 0,0,0,1,0);
        tbl[11] = v(0,0,0,1, 1,1,0,1,0);
        tbl[12] = v(0,0,0,0, 1,1,0,1,0);
        tbl[13] = v(0,0,0,1, 1,0,1,0,1);
        tbl[14] = v(0,0,0,1, 1,0,1,0,1);
        tbl[15] = v(0,0,0,0, 1,0,1,0,1);
        dec_var = 1000;
        for (int i = 0; i < 16; i++) begin
            start      = tbl[i].start;
            continuous = tbl[i].cont;
            abort      = tbl[i].abort;
            tick(tbl[i].en);
            chk_ctl($sformatf("vec%0d", i), tbl[i].clr, tbl[i].hld, tbl[i].vld,
                    tbl[i].bsy, tbl[i].cnt);
        end
        chk("oneshot_ref", ref_m, 1000);
        exp_cnt = 4'd1;

        // Test 3: continuous windows, alternating sign
        continuous = 1'b1;
        start = 1'b1;
        tick(1'b0);
        for (int w = 1; w <= 3; w++) begin
            dec_var = 600;
            n = 0;
            begin
                logic [3:0] prev;
                prev = window_count;
                while (window_count == prev && n < 20) begin
                    sym();
                    n++;
                    dec_var = -dec_var;
                end
            end
            exp_cnt = exp_cnt + 4'd1;
            chk($sformatf("cont_len%0d", w), n, (w == 1) ? 11 : 9);
            chk($sformatf("cont_ref%0d", w), ref_m, 600);
            chk($sformatf("cont_cnt%0d", w), window_count, exp_cnt);
        end

        // Test 4a: abort mid-ACCUM
        for (int i = 0; i < 5; i++) sym();
        abort = 1'b1;
        tick(1'b0);
        chk_ctl("abort_accum", 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
        chk("abort_ref", ref_m, 600);

        // Test 4b: abort coincident with the latching strobe
        continuous = 1'b0;
        dec_var = 600;
        start = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 10; i++) sym();
        chk_ctl("latch_reached", 1'b1, 1'b1, 1'b1, 1'b1, exp_cnt);
        tick(1'b0);
        abort = 1'b1;
        tick(1'b1);
        exp_cnt = exp_cnt + 4'd1;
        chk_ctl("abort_latch", 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
        start = 1'b1;
        abort = 1'b1;
        tick(1'b0);
        chk_ctl("start_abort", 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);

        // Test 5: clk_en stall mid-ACCUM, start ignored while busy
        dec_var = 800;
        start = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 5; i++) sym();
        for (int i = 0; i < 50; i++) begin
            start = (i == 25);
            tick(1'b0);
        end
        chk_ctl("stall_hold", 1'b0, 1'b0, 1'b1, 1'b1, exp_cnt);
        for (int i = 0; i < 4; i++) sym();
        chk_ctl("stall_7syms", 1'b0, 1'b0, 1'b1, 1'b1, exp_cnt);
        sym();
        chk_ctl("stall_latch", 1'b1, 1'b1, 1'b1, 1'b1, exp_cnt);
        sym();
        exp_cnt = exp_cnt + 4'd1;
        chk_ctl("stall_done", 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
        chk("stall_ref", ref_m, 800);

        // Test 6: counter wrap over 17 windows, then reset mid-window
        reset = 1'b1;
        tick(1'b0);
        chk_ctl("reset2", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        continuous = 1'b1;
        start = 1'b1;
        tick(1'b0);
        for (int w = 1; w <= 17; w++) begin
            dec_var = 100 + 10 * w;
            run_window(n);
            chk($sformatf("wrap_cnt%0d", w), window_count, w % 16);
            chk($sformatf("wrap_ref%0d", w), ref_m, 100 + 10 * w);
        end
        for (int i = 0; i < 3; i++) sym();
        reset = 1'b1;
        tick(1'b0);
        chk_ctl("reset_mid", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
